// File: rtl/sort4_serializer.sv
// Two-entry frame buffer that takes a 4-word sorted frame in parallel and streams
// it out one word per cycle. Frames violating y0<=y1<=y2<=y3 are flagged on all 4 words.
module sort4_serializer #(
   parameter int WIDTH   = 8,
   parameter bit DESCEND = 1'b0,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] y0,
   input  logic [WIDTH-1:0] y1,
   input  logic [WIDTH-1:0] y2,
   input  logic [WIDTH-1:0] y3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_idx,
   output logic             out_last,
   output logic             out_err,
   output logic [CNT_W-1:0] frame_cnt
);

   logic [1:0][3:0][WIDTH-1:0] r_buf;
   logic [1:0]                 r_err;
   logic                       r_wptr;
   logic                       r_rptr;
   logic [1:0]                 r_cnt;
   logic [1:0]                 r_idx;
   logic [CNT_W-1:0]           r_frame_cnt;

   logic       w_push;
   logic       w_xfer;
   logic       w_pop;
   logic       w_sorted;
   logic [1:0] w_sel;

   // in_ready looks only at the registered count, so a slot freed by the
   // final pop is not offered until the following cycle.
   assign in_ready  = (r_cnt != 2'd2);
   assign out_valid = (r_cnt != 2'd0);

   assign w_push   = in_valid & in_ready;
   assign w_xfer   = out_valid & out_ready;
   assign w_pop    = w_xfer & (r_idx == 2'd3);
   assign w_sorted = (y0 <= y1) && (y1 <= y2) && (y2 <= y3);
   assign w_sel    = r_idx ^ {2{DESCEND}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf <= '0;
         r_err <= '0;
      end else if (w_push) begin
         r_buf[r_wptr] <= {y3, y2, y1, y0};
         r_err[r_wptr] <= ~w_sorted;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr      <= 1'b0;
         r_rptr      <= 1'b0;
         r_cnt       <= 2'd0;
         r_idx       <= 2'd0;
         r_frame_cnt <= '0;
      end else begin
         if (w_push) r_wptr <= ~r_wptr;
         if (w_xfer) r_idx <= r_idx + 2'd1;
         if (w_pop) begin
            r_rptr      <= ~r_rptr;
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Idle outputs are forced to zero so an empty buffer shows no stale frame.
   assign out_data  = out_valid ? r_buf[r_rptr][w_sel] : '0;
   assign out_err   = out_valid ? r_err[r_rptr] : 1'b0;
   assign out_idx   = r_idx;
   assign out_last  = out_valid & (r_idx == 2'd3);
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_sort4_serializer.sv
// Bench for sort4_serializer: ascending (16-bit counter) and descending (3-bit
// counter) instances share stimulus and are compared against a frame-queue model.
module tb_sort4_serializer;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] y0, y1, y2, y3;

   logic        a_in_ready, a_out_valid, a_out_last, a_out_err;
   logic [7:0]  a_out_data;
   logic [1:0]  a_out_idx;
   logic [15:0] a_frame_cnt;

   logic        d_in_ready, d_out_valid, d_out_last, d_out_err;
   logic [7:0]  d_out_data;
   logic [1:0]  d_out_idx;
   logic [2:0]  d_frame_cnt;

   sort4_serializer #(.WIDTH(8), .DESCEND(1'b0), .CNT_W(16)) u_asc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .out_idx(a_out_idx), .out_last(a_out_last), .out_err(a_out_err),
      .frame_cnt(a_frame_cnt)
   );

   sort4_serializer #(.WIDTH(8), .DESCEND(1'b1), .CNT_W(3)) u_dsc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
      .out_idx(d_out_idx), .out_last(d_out_last), .out_err(d_out_err),
      .frame_cnt(d_frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] w[4];
      bit         err;
   } frame_t;

   frame_t q[$];
   int     idx;
   int     fcnt;
   int     errs;
   int     checks;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      frame_t f;
      chk("asc_in_ready",  a_in_ready,  q.size() < 2);
      chk("dsc_in_ready",  d_in_ready,  q.size() < 2);
      chk("asc_out_valid", a_out_valid, q.size() > 0);
      chk("dsc_out_valid", d_out_valid, q.size() > 0);
      chk("asc_frame_cnt", a_frame_cnt, fcnt % 65536);
      chk("dsc_frame_cnt", d_frame_cnt, fcnt % 8);
      if (q.size() > 0) begin
         f = q[0];
         chk("asc_data", a_out_data, f.w[idx]);
         chk("dsc_data", d_out_data, f.w[3-idx]);
         chk("asc_idx",  a_out_idx,  idx);
         chk("dsc_idx",  d_out_idx,  idx);
         chk("asc_last", a_out_last, idx == 3);
         chk("dsc_last", d_out_last, idx == 3);
         chk("asc_err",  a_out_err,  f.err);
         chk("dsc_err",  d_out_err,  f.err);
      end
   endtask

   task automatic chk_reset();
      chk("rst_asc_valid", a_out_valid, 0);
      chk("rst_dsc_valid", d_out_valid, 0);
      chk("rst_asc_idx",   a_out_idx,   0);
      chk("rst_dsc_idx",   d_out_idx,   0);
      chk("rst_asc_last",  a_out_last,  0);
      chk("rst_dsc_last",  d_out_last,  0);
      chk("rst_asc_err",   a_out_err,   0);
      chk("rst_dsc_err",   d_out_err,   0);
      chk("rst_asc_data",  a_out_data,  0);
      chk("rst_dsc_data",  d_out_data,  0);
      chk("rst_asc_cnt",   a_frame_cnt, 0);
      chk("rst_dsc_cnt",   d_frame_cnt, 0);
   endtask

   // One clock: drive inputs, advance the model at the edge, check at negedge.
   task automatic cycle(input bit iv, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d, input bit ordy,
                        output bit acc);
      bit     rdy, vld;
      frame_t f;
      logic [7:0] s[4];
      in_valid = iv; y0 = a; y1 = b; y2 = c; y3 = d; out_ready = ordy;
      rdy = q.size() < 2;
      vld = q.size() > 0;
      @(posedge clk);
      if (vld && ordy) begin
         if (idx == 3) begin
            void'(q.pop_front());
            idx = 0;
            fcnt++;
         end else idx++;
      end
      acc = iv && rdy;
      if (acc) begin
         f.w[0] = a; f.w[1] = b; f.w[2] = c; f.w[3] = d;
         s = f.w;
         s.sort();
         f.err = (s != f.w);
         q.push_back(f);
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n, input bit ordy);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, ordy, acc);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      bit acc;
      int tries;
      logic [7:0] r[4];
      errs = 0; checks = 0; idx = 0; fcnt = 0;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      y0 = 8'd0; y1 = 8'd0; y2 = 8'd0; y3 = 8'd0;
      repeat (2) @(negedge clk);
      chk_reset();
      rst = 1'b1;
      @(negedge clk);
      check_all();

      // basic frame, sorted with duplicates
      cycle(1'b1, 8'd3, 8'd7, 8'd7, 8'd200, 1'b1, acc);
      idle(5, 1'b1);
      chk("basic_frame_cnt", a_frame_cnt, 1);
      cycle(1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1, acc);
      idle(5, 1'b1);

      // stalled sink: two frames accepted, third waits for the head to drain
      cycle(1'b1, 8'd10, 8'd11, 8'd12, 8'd13, 1'b0, acc);
      cycle(1'b1, 8'd20, 8'd21, 8'd22, 8'd23, 1'b0, acc);
      cycle(1'b1, 8'd30, 8'd31, 8'd32, 8'd33, 1'b0, acc);
      chk("third_refused", acc, 0);
      idle(3, 1'b0);
      tries = 0;
      do begin
         cycle(1'b1, 8'd30, 8'd31, 8'd32, 8'd33, 1'b1, acc);
         tries++;
      end while (!acc && tries < 20);
      chk("third_accepted", acc, 1);
      chk("third_wait", tries, 5);
      idle(12, 1'b1);

      // unsorted frame then sorted frame
      cycle(1'b1, 8'd9, 8'd5, 8'd6, 8'd7, 1'b1, acc);
      cycle(1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b1, acc);
      idle(9, 1'b1);

      // continuous push and drain
      for (int i = 0; i < 48; i++)
         cycle(1'b1, 8'(i), 8'(i+1), 8'(i+2), 8'(i+3), 1'b1, acc);
      idle(10, 1'b1);

      // reset after two words of a frame
      cycle(1'b1, 8'd40, 8'd50, 8'd60, 8'd70, 1'b1, acc);
      idle(2, 1'b1);
      rst = 1'b0;
      q.delete(); idx = 0; fcnt = 0;
      #1;
      chk_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all();
      cycle(1'b1, 8'd5, 8'd6, 8'd7, 8'd8, 1'b1, acc);
      chk("post_rst_idx", a_out_idx, 0);
      idle(5, 1'b1);

      // random traffic
      for (int i = 0; i < 500; i++) begin
         for (int k = 0; k < 4; k++) r[k] = 8'($urandom);
         if ($urandom_range(0, 3) != 0) r.sort();
         cycle($urandom_range(0, 3) != 0, r[0], r[1], r[2], r[3],
               $urandom_range(0, 3) != 0, acc);
      end
      idle(12, 1'b1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/sort4_serializer.md
Name: sort4_serializer

Overview:
- Consumer-side companion to the 4-input pipelined sorter.
- Accepts one parallel frame of four sorted words (y0..y3) per valid/ready handshake and buffers up to two frames.
- Streams the words out one per cycle over a valid/ready serial interface, in ascending or descending order.
- Flags frames whose inputs violate sorted order and counts completed frames.

Parameters:
- WIDTH, 8, bit width of each data word.
- DESCEND, 0, 0 = emit y0,y1,y2,y3; 1 = emit y3,y2,y1,y0.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; state clears while rst=0.
- in_valid  input  1  frame y0..y3 present.
- in_ready  output  1  block can accept a frame.
- y0  input  WIDTH  smallest sorted word.
- y1  input  WIDTH  second word.
- y2  input  WIDTH  third word.
- y3  input  WIDTH  largest word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  current serial word.
- out_idx  output  2  position of the word within its frame in emission order, 0..3.
- out_last  output  1  high with the 4th word of a frame (out_idx=3).
- out_err  output  1  current frame failed the check y0<=y1<=y2<=y3 (unsigned); held for all 4 words.
- frame_cnt  output  CNT_W  number of frames fully emitted; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous):
  - buffer is emptied, read/write pointers and word index go to 0.
  - frame_cnt=0, out_valid=0, out_idx=0, out_last=0, out_err=0, out_data=0.
  - in_ready=1 once rst returns high.
- Storage:
  - 2-entry frame buffer; each entry holds 4 words plus 1 err bit.
  - Write pointer, read pointer and count are all registers.
- Handshake and flow control:
  - Push occurs on a rising edge with in_valid=1 and in_ready=1.
  - in_ready = (count<2). It depends only on registered count; there is no combinational path from out_ready.
  - When full, in_ready=0 even in a cycle where the last word of the head frame pops. The freed slot is visible the next cycle.
  - The err bit is computed from y0..y3 at push time and stored with the entry.
- Output stream:
  - out_valid = (count>0). out_data, out_idx, out_last and out_err come from the head entry and the word-index register.
  - All outputs are driven from registers through a mux only.
  - Word transfer occurs when out_valid=1 and out_ready=1; the word index increments by 1.
  - On transfer with index 3: the index wraps to 0, the head frame pops (read pointer toggles, count decrements) and frame_cnt increments.
- Word selection:
  - DESCEND=0: index i selects y_i.
  - DESCEND=1: index i selects y_(3-i).
- Stall: out_valid=1 with out_ready=0 holds out_data, out_idx, out_last and out_err stable. out_valid never drops without a transfer.
- Simultaneous push and final pop: count is unchanged, both pointers advance, and the stream continues with no bubble.
- Latency and throughput:
  - A frame pushed at edge k into an empty buffer gives out_valid=1 in the cycle after edge k, with out_idx=0.
  - With out_ready held high, sustained throughput is 1 word/cycle, i.e. 1 frame per 4 cycles.
- Reset mid-stream discards all buffered and partially emitted frames; no partial frame resumes after reset.
- Wrap: frame_cnt rolls from 2^CNT_W-1 to 0 without a flag.

Test Plan:
- Reset then push {y0..y3}={3,7,7,200} with out_ready=1, DESCEND=0 -> out_data 3,7,7,200 on 4 consecutive cycles; out_idx 0..3; out_last only on 200; out_err=0; frame_cnt=1.
- DESCEND=1, push {1,2,3,4} -> out_data 4,3,2,1; out_last with 1.
- out_ready=0, push 3 frames back-to-back -> first two accepted; in_ready=0 on the third until 4 words have been drained; out_data is held stable while stalled.
- Push {9,5,6,7} (unsorted) followed by {1,2,3,4} -> out_err=1 for all 4 words of the first frame and 0 for the second.
- Full buffer, out_ready=1, in_valid=1 continuously -> no bubble in out_valid; frame_cnt increments every 4 cycles; in_ready=0 on the final-pop cycle of each frame.
- Assert rst=0 after 2 words of a frame, then release -> out_valid=0, frame_cnt=0, in_ready=1; the next pushed frame starts at out_idx=0.
